// File: rtl/seg_scan_driver_if.sv
// Frame load port of seg_scan_driver: ready/valid handshake carrying one
// frame of DIGITS glyph codes (digit k at bits [k*5+4 : k*5]).
interface seg_scan_driver_if #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned CODE_W = 5
) ();
    logic                       load;
    logic [DIGITS*CODE_W-1:0]   code_in;
    logic                       ready;

    modport master (output load, output code_in, input  ready);
    modport slave  (input  load, input  code_in, output ready);
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment display driver.
// Glyph codes arrive a frame at a time on the load port, are double-buffered
// (shadow + pending) and swapped into the active frame only at the scan wrap,
// so a frame is never shown half old and half new.
// Optional feature macro: SEG_SCAN_BLINK_EN (adds BLINK_FRAMES and blink_mask).
module seg_scan_driver #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 1000,
    parameter int unsigned CODE_W   = 5
`ifdef SEG_SCAN_BLINK_EN
    ,
    parameter int unsigned BLINK_FRAMES = 32
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    seg_scan_driver_if.slave    bus,
`ifdef SEG_SCAN_BLINK_EN
    input  logic [DIGITS-1:0]   blink_mask,
`endif
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   dig_en,
    output logic                frame_tick
);

    localparam int unsigned IDX_W = (DIGITS   > 1) ? $clog2(DIGITS)   : 1;
    localparam int unsigned PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned FR_W  = DIGITS * CODE_W;

    function automatic logic [6:0] decode(input logic [CODE_W-1:0] c);
        case (c)
            5'd0:    decode = 7'b1111110;
            5'd1:    decode = 7'b0110000;
            5'd2:    decode = 7'b1101101;
            5'd3:    decode = 7'b1111001;
            5'd4:    decode = 7'b0110011;
            5'd5:    decode = 7'b1011011;
            5'd6:    decode = 7'b1011111;
            5'd7:    decode = 7'b1110000;
            5'd8:    decode = 7'b1111111;
            5'd9:    decode = 7'b1111011;
            5'd10:   decode = 7'b1110111;
            5'd11:   decode = 7'b0011111;
            5'd12:   decode = 7'b1001110;
            5'd13:   decode = 7'b0111101;
            5'd14:   decode = 7'b1001111;
            5'd15:   decode = 7'b1000111;
            5'd17:   decode = 7'b0000001;
            default: decode = 7'b0000000;
        endcase
    endfunction

    // Blank glyph (16) replicated across the frame.
    function automatic logic [FR_W-1:0] blank_frame();
        logic [FR_W-1:0] f;
        f = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            f[k*CODE_W +: CODE_W] = CODE_W'(16);
        end
        return f;
    endfunction

    logic [PS_W-1:0]    presc_q,   presc_d;
    logic [IDX_W-1:0]   idx_q,     idx_d;
    logic [FR_W-1:0]    active_q,  active_d;
    logic [FR_W-1:0]    shadow_q,  shadow_d;
    logic               pending_q, pending_d;
    logic               running_q, running_d;
    logic [6:0]         seg_q,     seg_d;
    logic [DIGITS-1:0]  dig_en_q,  dig_en_d;
    logic               tick_q,    tick_d;
    logic               wrap;
    logic               accept;

`ifdef SEG_SCAN_BLINK_EN
    localparam int unsigned BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [BC_W-1:0]    bcnt_q,    bcnt_d;
    logic               boff_q,    boff_d;
`endif

    assign bus.ready  = !pending_q;
    assign accept     = bus.load && !pending_q;
    assign seg        = seg_q;
    assign dig_en     = dig_en_q;
    assign frame_tick = tick_q;

    // Next-state: prescaler/index advance, double-buffer swap and load capture.
    // running_q holds the scan on its first post-reset cycle so that digit 0
    // gets its full PRESCALE-cycle slot in the first frame as in every other.
    always_comb begin
        presc_d   = presc_q;
        idx_d     = idx_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        running_d = 1'b1;
        wrap      = 1'b0;

        if (running_q) begin
            if (presc_q == PS_W'(PRESCALE - 1)) begin
                presc_d = '0;
                if (idx_q == IDX_W'(DIGITS - 1)) begin
                    idx_d = '0;
                    wrap  = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end

        if (wrap && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end

        if (accept) begin
            if (wrap) begin
                active_d = bus.code_in;
            end else begin
                shadow_d  = bus.code_in;
                pending_d = 1'b1;
            end
        end
    end

`ifdef SEG_SCAN_BLINK_EN
    // Blink phase toggles every BLINK_FRAMES frame boundaries.
    always_comb begin
        bcnt_d = bcnt_q;
        boff_d = boff_q;
        if (wrap) begin
            if (bcnt_q == BC_W'(BLINK_FRAMES - 1)) begin
                bcnt_d = '0;
                boff_d = !boff_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
    end
`endif

    // Output pattern from the post-update index and active frame.
    always_comb begin
        seg_d    = decode(active_d[int'(idx_d)*CODE_W +: CODE_W]);
        dig_en_d = DIGITS'(1) << idx_d;
        tick_d   = wrap;
`ifdef SEG_SCAN_BLINK_EN
        if (boff_d && blink_mask[idx_d]) begin
            seg_d = '0;
        end
`endif
    end

    // Scan and frame-buffer state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            idx_q     <= '0;
            active_q  <= blank_frame();
            shadow_q  <= blank_frame();
            pending_q <= 1'b0;
            running_q <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            running_q <= running_d;
        end
    end

`ifdef SEG_SCAN_BLINK_EN
    // Blink frame counter and phase; phase resets to "on".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q <= '0;
            boff_q <= 1'b0;
        end else begin
            bcnt_q <= bcnt_d;
            boff_q <= boff_d;
        end
    end
`endif

    // Registered pin outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q    <= '0;
            dig_en_q <= '0;
            tick_q   <= 1'b0;
        end else begin
            seg_q    <= seg_d;
            dig_en_q <= dig_en_d;
            tick_q   <= tick_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (DIGITS=4, PRESCALE=4).
// Reference model: scan position derived arithmetically from the number of
// clock edges since reset release; frame contents tracked per load rules.
`timescale 1ns/1ps
module tb_seg_scan_driver;
    localparam int unsigned D  = 4;
    localparam int unsigned P  = 4;
    localparam int unsigned FR = D * P;
`ifdef SEG_SCAN_BLINK_EN
    localparam int unsigned BF = 2;
    logic [D-1:0] blink_mask;
`endif

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic [6:0]   seg;
    logic [D-1:0] dig_en;
    logic         frame_tick;

    int checks = 0;
    int errors = 0;

    seg_scan_driver_if #(.DIGITS(D), .CODE_W(5)) bus ();

    seg_scan_driver #(
        .DIGITS(D),
        .PRESCALE(P),
        .CODE_W(5)
`ifdef SEG_SCAN_BLINK_EN
        ,
        .BLINK_FRAMES(BF)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
`ifdef SEG_SCAN_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .seg(seg),
        .dig_en(dig_en),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [6:0]   dec_tab [32];
    logic [4:0]   disp    [D];
    logic [4:0]   pend    [D];
    bit           pend_v;
    int           n;
    logic [D-1:0] exp_dig;
    logic [6:0]   exp_seg;
    logic         exp_tick;
    logic         exp_ready;

    task automatic model_reset();
        n = 0;
        pend_v = 1'b0;
        for (int k = 0; k < D; k++) begin
            disp[k] = 5'd16;
            pend[k] = 5'd16;
        end
        exp_dig = '0; exp_seg = '0; exp_tick = 1'b0; exp_ready = 1'b1;
    endtask

    // Advance one clock: update the model at the rising edge, return at the
    // following falling edge where DUT outputs are sampled.
    task automatic step();
        bit bnd, acc;
        int dg;
        @(posedge clk);
        if (rst_n) begin
            n++;
            bnd = (n > 1) && ((n - 1) % FR == 0);
            acc = bus.load && !pend_v;
            if (bnd && pend_v) begin
                for (int k = 0; k < D; k++) disp[k] = pend[k];
                pend_v = 1'b0;
            end
            if (acc) begin
                for (int k = 0; k < D; k++) begin
                    if (bnd) disp[k] = bus.code_in[k*5 +: 5];
                    else     pend[k] = bus.code_in[k*5 +: 5];
                end
                if (!bnd) pend_v = 1'b1;
            end
            dg        = ((n - 1) / P) % D;
            exp_dig   = D'(1) << dg;
            exp_seg   = dec_tab[disp[dg]];
`ifdef SEG_SCAN_BLINK_EN
            if (((((n - 1) / FR) / BF) % 2 == 1) && blink_mask[dg]) exp_seg = '0;
`endif
            exp_tick  = bnd;
            exp_ready = !pend_v;
        end
        @(negedge clk);
    endtask

    function automatic logic [19:0] rand_frame();
        return 20'($urandom);
    endfunction

    task automatic do_reset();
        bus.load = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b1;
        bus.load = 1'b0;
        bus.code_in = '0;
        #1 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({dig_en, seg, frame_tick, bus.ready} !== {4'b0000, 7'b0000000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_values: dig_en=%b seg=%b tick=%b ready=%b, expected 0000 0000000 0 1",
                     dig_en, seg, frame_tick, bus.ready);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3 * FR + 2; c++) begin
            step();
            checks++;
            if ({dig_en, seg, frame_tick, bus.ready} !== {exp_dig, exp_seg, exp_tick, exp_ready}) begin
                errors++;
                $display("FAIL idle_scan n=%0d: got %b %b %b %b, expected %b %b %b %b", n,
                         dig_en, seg, frame_tick, bus.ready, exp_dig, exp_seg, exp_tick, exp_ready);
            end
            checks++;
            if (seg !== 7'b0000000) begin
                errors++;
                $display("FAIL idle_blank n=%0d: seg=%b, expected 0000000", n, seg);
            end
        end
    endtask

    task automatic test_load_midframe();
        logic [6:0] want [D];
        bit seen_tick;
        want[0] = 7'b1111110; want[1] = 7'b0000001;
        want[2] = 7'b1110111; want[3] = 7'b1111111;
        while (n % FR != 6) step();
        bus.code_in = {5'd8, 5'd10, 5'd17, 5'd0};
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        checks++;
        if (bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL load_ready_drop: ready=%b, expected 0", bus.ready);
        end
        seen_tick = 1'b0;
        for (int c = 0; c < 2 * FR; c++) begin
            step();
            checks++;
            if ({dig_en, seg, frame_tick, bus.ready} !== {exp_dig, exp_seg, exp_tick, exp_ready}) begin
                errors++;
                $display("FAIL load_scan n=%0d: got %b %b %b %b, expected %b %b %b %b", n,
                         dig_en, seg, frame_tick, bus.ready, exp_dig, exp_seg, exp_tick, exp_ready);
            end
            if (frame_tick === 1'b1) seen_tick = 1'b1;
            checks++;
            if (bus.ready !== seen_tick) begin
                errors++;
                $display("FAIL load_ready_rise n=%0d: ready=%b, expected %b", n, bus.ready, seen_tick);
            end
            if (seen_tick) begin
                for (int k = 0; k < D; k++) begin
                    if (dig_en == D'(1) << k) begin
                        checks++;
                        if (seg !== want[k]) begin
                            errors++;
                            $display("FAIL load_glyph digit%0d: seg=%b, expected %b", k, seg, want[k]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_ignored_load();
        logic [19:0] fa, fb;
        fa = rand_frame();
        fb = ~fa;
        while (n % FR != 3) step();
        bus.code_in = fa;
        bus.load = 1'b1;
        step();
        bus.code_in = fb;
        step();
        step();
        bus.load = 1'b0;
        for (int c = 0; c < 2 * FR; c++) begin
            step();
            checks++;
            if ({dig_en, seg, frame_tick, bus.ready} !== {exp_dig, exp_seg, exp_tick, exp_ready}) begin
                errors++;
                $display("FAIL ignored_load n=%0d: got %b %b %b %b, expected %b %b %b %b", n,
                         dig_en, seg, frame_tick, bus.ready, exp_dig, exp_seg, exp_tick, exp_ready);
            end
        end
        for (int k = 0; k < D; k++) begin
            checks++;
            if (disp[k] !== fa[k*5 +: 5]) begin
                errors++;
                $display("FAIL ignored_frame digit%0d: model shows %0d, expected first load %0d",
                         k, disp[k], fa[k*5 +: 5]);
            end
        end
    endtask

    task automatic test_boundary_load();
        logic [19:0] f;
        f = rand_frame();
        while (n % FR != 0) step();
        bus.code_in = f;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        checks++;
        if ({dig_en, seg, frame_tick, bus.ready} !== {4'b0001, dec_tab[f[4:0]], 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL boundary_load: got %b %b %b %b, expected 0001 %b 1 1",
                     dig_en, seg, frame_tick, bus.ready, dec_tab[f[4:0]]);
        end
        for (int c = 0; c < FR; c++) begin
            step();
            checks++;
            if ({dig_en, seg, frame_tick, bus.ready} !== {exp_dig, exp_seg, exp_tick, 1'b1}) begin
                errors++;
                $display("FAIL boundary_hold n=%0d: got %b %b %b %b, expected %b %b %b 1", n,
                         dig_en, seg, frame_tick, bus.ready, exp_dig, exp_seg, exp_tick);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.load = ($urandom_range(0, 5) == 0);
            bus.code_in = rand_frame();
            step();
            checks++;
            if ({dig_en, seg, frame_tick, bus.ready} !== {exp_dig, exp_seg, exp_tick, exp_ready}) begin
                errors++;
                $display("FAIL random n=%0d: got %b %b %b %b, expected %b %b %b %b", n,
                         dig_en, seg, frame_tick, bus.ready, exp_dig, exp_seg, exp_tick, exp_ready);
            end
            checks++;
            if ($countones(dig_en) != 1) begin
                errors++;
                $display("FAIL onehot n=%0d: dig_en=%b, expected exactly one bit", n, dig_en);
            end
        end
        bus.load = 1'b0;
    endtask

    task automatic test_async_reset();
        while (n % FR != 5) step();
        bus.code_in = {5'd1, 5'd2, 5'd3, 5'd4};
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        step();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({dig_en, seg, frame_tick, bus.ready} !== {4'b0000, 7'b0000000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset: got %b %b %b %b, expected 0000 0000000 0 1",
                     dig_en, seg, frame_tick, bus.ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 2 * FR + 2; c++) begin
            step();
            checks++;
            if ({dig_en, seg, frame_tick, bus.ready} !== {exp_dig, 7'b0000000, exp_tick, 1'b1}) begin
                errors++;
                $display("FAIL post_reset n=%0d: got %b %b %b %b, expected %b 0000000 %b 1", n,
                         dig_en, seg, frame_tick, bus.ready, exp_dig, exp_tick);
            end
        end
    endtask

`ifdef SEG_SCAN_BLINK_EN
    task automatic test_blink();
        blink_mask = 4'b0010;
        do_reset();
        bus.code_in = {4{5'd8}};
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        for (int c = 0; c < 7 * FR; c++) begin
            step();
            checks++;
            if ({dig_en, seg, frame_tick, bus.ready} !== {exp_dig, exp_seg, exp_tick, exp_ready}) begin
                errors++;
                $display("FAIL blink n=%0d: got %b %b %b %b, expected %b %b %b %b", n,
                         dig_en, seg, frame_tick, bus.ready, exp_dig, exp_seg, exp_tick, exp_ready);
            end
        end
        blink_mask = '0;
    endtask
`endif

    initial begin
        dec_tab[0]  = 7'b1111110; dec_tab[1]  = 7'b0110000; dec_tab[2]  = 7'b1101101;
        dec_tab[3]  = 7'b1111001; dec_tab[4]  = 7'b0110011; dec_tab[5]  = 7'b1011011;
        dec_tab[6]  = 7'b1011111; dec_tab[7]  = 7'b1110000; dec_tab[8]  = 7'b1111111;
        dec_tab[9]  = 7'b1111011; dec_tab[10] = 7'b1110111; dec_tab[11] = 7'b0011111;
        dec_tab[12] = 7'b1001110; dec_tab[13] = 7'b0111101; dec_tab[14] = 7'b1001111;
        dec_tab[15] = 7'b1000111;
        for (int i = 16; i < 32; i++) dec_tab[i] = 7'b0000000;
        dec_tab[17] = 7'b0000001;
`ifdef SEG_SCAN_BLINK_EN
        blink_mask = '0;
`endif
        test_reset();
        test_load_midframe();
        test_ignored_load();
        test_boundary_load();
        test_random();
        test_async_reset();
`ifdef SEG_SCAN_BLINK_EN
        test_blink();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised, time-multiplexed seven-segment display driver. Accepts a frame of DIGITS 5-bit glyph codes through a ready/valid load port. It decodes each code to a registered 7-bit segment pattern and scans the digits one at a time with a one-hot digit enable. New frames are double-buffered and swapped only at a frame boundary, so a display is never shown half old and half new. The block sits between the display controller logic and the physical segment/digit pins.

## Interface
- DIGITS, 4: number of multiplexed digits, ≥1.
- PRESCALE, 1000: clock cycles each digit stays enabled, ≥1.
- CODE_W, 5: glyph code width; fixed at 5, the decoder is defined only for 5.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- load  in  1  valid: a frame is presented on code_in.
- code_in  in  DIGITS*CODE_W  frame; digit k at bits [k*5+4 : k*5].
- ready  out  1  frame buffer can accept a load.
- seg  out  7  {a,b,c,d,e,f,g}; a is the MSB; 1 = segment lit.
- dig_en  out  DIGITS  one-hot active-high digit enable.
- frame_tick  out  1  one-cycle pulse on the cycle the scan wraps to digit 0.

## Operation
- Decode table, {a..g}:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000.
  - 8=1111111, 9=1111011, 10(A)=1110111, 11(b)=0011111, 12(C)=1001110, 13(d)=0111101, 14(E)=1001111, 15(F)=1000111.
  - 17(minus)=0000001.
  - 16 and 18–31 = 0000000 (blank).
- Prescaler: counts 0..PRESCALE-1. At its terminal count the digit index advances, wrapping DIGITS-1→0.
- Active register: DIGITS codes currently scanned. Reset value is all 16 (blank).
- Shadow register plus a pending flag. ready = !pending.
- Load rules:
  - Load accepted: load && ready. Otherwise the load is ignored and code_in is not sampled.
  - Accepted load, not on a boundary edge: code_in goes to shadow and pending is set.
  - Frame boundary edge (index wraps to 0): if pending, shadow goes to active and pending clears.
  - Accepted load on the boundary edge: code_in goes directly to active, pending stays 0 and ready stays 1.
- Output datapath:
  - seg and dig_en are registered from the post-update index and active register.
  - Digit k shows decode(active[k]) while dig_en[k]=1.
- DIGITS=1: every prescaler terminal count is a frame boundary.

## Timing
- Reset values: seg=0000000, dig_en=0, frame_tick=0, ready=1, index=0, prescaler=0, pending=0.
- First rising edge after rst_n deasserts: dig_en=…0001, seg=decode(active[0]).
- Digit k is enabled for exactly PRESCALE cycles. A full frame is DIGITS*PRESCALE cycles.
- frame_tick is high for one cycle, coincident with the first cycle of dig_en[0].
- Accepted load: ready goes low the next cycle. It returns high on the boundary edge, where the new codes appear on seg in the same cycle as dig_en[0].
- Load-to-display latency: 1 to DIGITS*PRESCALE cycles.
- Asynchronous reset mid-frame or mid-pending: all state returns to reset values immediately and the pending frame is discarded.
- dig_en never has more than one bit set, and is never all-zero outside reset.

## Configuration
- Macro: SEG_SCAN_BLINK_EN.
- Defined:
  - Adds parameter BLINK_FRAMES (default 32) and port blink_mask, in, DIGITS bits, sampled every cycle.
  - A frame counter toggles a blink phase every BLINK_FRAMES frame boundaries; the phase resets to "on".
  - In the "off" phase, a digit whose blink_mask bit is set shows seg=0000000 while dig_en still scans normally.
- Undefined: no port, no parameter, no frame counter; all digits always shown.

## Test plan
Conditions for all scenarios: DIGITS=4, PRESCALE=4.
- Reset release, no load:
  - dig_en cycles 0001→0010→0100→1000, 4 cycles each.
  - seg=0000000 throughout.
  - frame_tick pulses every 16 cycles.
- Load codes {3:8, 2:10, 1:17, 0:0} mid-frame:
  - ready drops the next cycle.
  - At the next boundary the scan shows digit0=1111110, digit1=0000001, digit2=1110111, digit3=1111111.
  - ready rises with frame_tick.
- Second load while ready=0: ignored; the displayed frame equals the first load.
- Load asserted on the boundary cycle with ready=1: the new codes are shown immediately on digit 0 and ready never drops.
- rst_n pulsed low while pending: all outputs return to reset values and, after release, seg stays blank.
- SEG_SCAN_BLINK_EN defined, BLINK_FRAMES=2, blink_mask=0010, all codes 8:
  - Digit 1 shows 1111111 for 2 frames, then 0000000 for 2 frames, repeating.
  - The other digits always show 1111111.
